zle_arb2: RTL and testbench

ZLE_ARB2 -- requirements
Module: zle_arb2

---
 rtl/zle_arb2.sv | 147 ++++++++++++++
 tb/tb_zle_arb2.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/zle_arb2.sv
// -----------------------------------------------------------------------------
// zle_arb2 -- two-source burst arbiter in front of a shared zero-run encoder.
//
// Grants one source (A or B) at a time for a burst of BURST accepted tokens.
// While a grant is active, the granted stream is passed straight through
// combinationally to the encoder. When a grant ends, a one-cycle o_rel pulse
// lets the encoder flush its pending zero run before the other source is
// granted. When both sources are valid, round-robin selects between them.
//
// Optional feature macro: ZLE_ARB_EARLY_REL_EN
//   When this macro is defined, a granted source that stays invalid for
//   IDLE_MAX consecutive cycles loses its grant early.
//
// Parameters:
//   W        data width of every stream
//   BURST    accepted tokens per grant (2..255)
//   IDLE_MAX starved cycles before early release (macro builds only)
//
// Ports:
//   clock, reset        single clock; synchronous active-high reset
//   a_d/a_v/a_b         requester A data, valid, backpressure (out)
//   b_d/b_v/b_b         requester B data, valid, backpressure (out)
//   o_d/o_v/o_b         stream to the encoder (o_b is backpressure in)
//   o_sel               source of the current grant (0=A, 1=B)
//   o_rel               one-cycle end-of-grant pulse
// -----------------------------------------------------------------------------
module zle_arb2 #(
  parameter int W        = 7,
  parameter int BURST    = 8,
  parameter int IDLE_MAX = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] a_d,
  input  logic         a_v,
  output logic         a_b,
  input  logic [W-1:0] b_d,
  input  logic         b_v,
  output logic         b_b,
  output logic [W-1:0] o_d,
  output logic         o_v,
  input  logic         o_b,
  output logic         o_sel,
  output logic         o_rel
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, REL} state_t;

  localparam logic [7:0] CNT_LAST = 8'(BURST - 1);

  state_t     state_q;
  logic       rr_q;      // 0: A wins a tie, 1: B wins a tie
  logic [7:0] cnt_q;     // tokens accepted in the current grant
  logic       xfer;      // output transfer this cycle
  logic       gnt_v;     // valid of the currently granted source

  // Outputs are decoded from the state with a combinational data mux.
  // The reset input overrides everything, so a cycle with reset high can
  // never carry a transfer or a release pulse.
  always_comb begin
    a_b   = 1'b1;
    b_b   = 1'b1;
    o_v   = 1'b0;
    o_d   = a_d;
    o_sel = 1'b0;
    o_rel = 1'b0;
    if (!reset) begin
      case (state_q)
        GNT_A: begin
          o_v = a_v;
          a_b = o_b;
          o_d = a_d;
        end
        GNT_B: begin
          o_v   = b_v;
          b_b   = o_b;
          o_d   = b_d;
          o_sel = 1'b1;
        end
        REL:     o_rel = 1'b1;
        default: ;
      endcase
    end
  end

  assign xfer  = o_v && !o_b;
  assign gnt_v = (state_q == GNT_B) ? b_v : a_v;

`ifdef ZLE_ARB_EARLY_REL_EN
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_MAX - 1);
  logic [7:0] idle_q;    // consecutive cycles the granted source was invalid
`else
  logic unused_idle_max;
  assign unused_idle_max = (IDLE_MAX != 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef ZLE_ARB_EARLY_REL_EN
      idle_q  <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 8'd0;
`ifdef ZLE_ARB_EARLY_REL_EN
          idle_q <= 8'd0;
`endif
          if (a_v && b_v)  state_q <= rr_q ? GNT_B : GNT_A;
          else if (a_v)    state_q <= GNT_A;
          else if (b_v)    state_q <= GNT_B;
        end
        GNT_A, GNT_B: begin
          if (xfer) begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == CNT_LAST) begin
              state_q <= REL;
              rr_q    <= (state_q == GNT_A);  // point at the other source
            end
          end
`ifdef ZLE_ARB_EARLY_REL_EN
          // A transfer implies gnt_v=1, so this never races the burst end.
          if (gnt_v) begin
            idle_q <= 8'd0;
          end else if (idle_q == IDLE_LAST) begin
            state_q <= REL;
            rr_q    <= (state_q == GNT_A);
          end else begin
            idle_q <= idle_q + 8'd1;
          end
`endif
        end
        REL:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef ZLE_ARB_EARLY_REL_EN
  logic unused_gnt_v;
  assign unused_gnt_v = gnt_v;
`endif

endmodule

// File: tb/tb_zle_arb2.sv
// -----------------------------------------------------------------------------
// tb_zle_arb2 -- directed self-checking bench for zle_arb2 (default params:
// W=7, BURST=8, IDLE_MAX=4). Each scenario lists, cycle by cycle, the state
// the arbiter must be in; step() turns that state into expected port values.
// -----------------------------------------------------------------------------
module tb_zle_arb2;

  localparam int W = 7;

  localparam int S_IDLE = 0;
  localparam int S_A    = 1;
  localparam int S_B    = 2;
  localparam int S_REL  = 3;
  localparam int S_RST  = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] a_d, b_d, o_d;
  logic         a_v, a_b, b_v, b_b, o_v, o_b, o_sel, o_rel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  zle_arb2 #(.W(W), .BURST(8), .IDLE_MAX(4)) dut (
    .clock (clock),
    .reset (reset),
    .a_d   (a_d),
    .a_v   (a_v),
    .a_b   (a_b),
    .b_d   (b_d),
    .b_v   (b_v),
    .b_b   (b_b),
    .o_d   (o_d),
    .o_v   (o_v),
    .o_b   (o_b),
    .o_sel (o_sel),
    .o_rel (o_rel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Check all outputs at the falling edge against the given expected state,
  // then advance to just after the next rising edge.
  task automatic step(input string tag, input int st);
    logic         e_ab, e_bb, e_ov, e_rel, e_sel;
    logic [W-1:0] e_od;
    bit           do_sel, do_od;
    @(negedge clock);
    e_ab = 1'b1; e_bb = 1'b1; e_ov = 1'b0; e_rel = 1'b0;
    e_sel = 1'b0; e_od = '0; do_sel = 1'b0; do_od = 1'b0;
    case (st)
      S_A: begin
        e_ov = a_v; e_ab = o_b; e_sel = 1'b0; e_od = a_d;
        do_sel = 1'b1; do_od = 1'b1;
      end
      S_B: begin
        e_ov = b_v; e_bb = o_b; e_sel = 1'b1; e_od = b_d;
        do_sel = 1'b1; do_od = 1'b1;
      end
      S_REL: e_rel = 1'b1;
      S_RST: do_sel = 1'b1;
      default: ;
    endcase
    check({tag, " a_b"},   32'(a_b),   32'(e_ab));
    check({tag, " b_b"},   32'(b_b),   32'(e_bb));
    check({tag, " o_v"},   32'(o_v),   32'(e_ov));
    check({tag, " o_rel"}, 32'(o_rel), 32'(e_rel));
    if (do_sel) check({tag, " o_sel"}, 32'(o_sel), 32'(e_sel));
    if (do_od)  check({tag, " o_d"},   32'(o_d),   32'(e_od));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; a_v = 1'b0; b_v = 1'b0; o_b = 1'b0;
    step("reset", S_RST);
    reset = 1'b0;
  endtask

  initial begin
    int p, st, tok;
    reset = 1'b1; a_v = 1'b1; b_v = 1'b1; o_b = 1'b0;
    a_d = 7'h12; b_d = 7'h34;

    // Reset state with both sources requesting.
    step("rst0", S_RST);
    step("rst1", S_RST);

    // A only, continuous: 8 transfers, REL, IDLE, period 10.
    do_reset();
    a_v = 1'b1; b_d = 7'h55;
    for (int c = 0; c < 21; c++) begin
      p = c % 10;
      a_d = 7'(c + 1);
      st = (p == 0) ? S_IDLE : (p == 9) ? S_REL : S_A;
      step($sformatf("onlyA c%0d", c), st);
    end

    // Both valid continuously: A,B,A,B grants of 8.
    do_reset();
    a_v = 1'b1; b_v = 1'b1;
    for (int c = 0; c < 41; c++) begin
      p = c % 10;
      a_d = 7'(c);
      b_d = 7'(100 - c);
      st = (p == 0) ? S_IDLE : (p == 9) ? S_REL : (((c / 10) % 2) == 1) ? S_B : S_A;
      step($sformatf("rr c%0d", c), st);
    end

    // Encoder stall of 5 cycles after the 3rd transfer of an A grant.
    do_reset();
    a_v = 1'b1; b_v = 1'b0; b_d = 7'h7f; tok = 0;
    for (int c = 0; c < 16; c++) begin
      o_b = (c >= 4 && c <= 8);
      a_d = 7'(tok);
      st = (c == 0 || c == 15) ? S_IDLE : (c == 14) ? S_REL : S_A;
      step($sformatf("stall c%0d", c), st);
      if (st == S_A && !o_b) tok++;
    end
    o_b = 1'b0;

    // A starves for 6 cycles after 2 transfers while B waits.
    do_reset();
    a_v = 1'b1; b_v = 1'b1; a_d = 7'h0a; b_d = 7'h0b;
    for (int c = 0; c < 11; c++) begin
      a_v = !(c >= 3 && c <= 8);
`ifdef ZLE_ARB_EARLY_REL_EN
      st = (c == 0 || c == 8) ? S_IDLE : (c == 7) ? S_REL : (c >= 9) ? S_B : S_A;
`else
      st = (c == 0) ? S_IDLE : S_A;
`endif
      step($sformatf("starve c%0d", c), st);
    end

    // Reset pulse at the 4th transfer of a B grant; A must win afterwards.
    do_reset();
    a_v = 1'b1; b_v = 1'b1; a_d = 7'h01; b_d = 7'h02;
    for (int c = 0; c < 17; c++) begin
      reset = (c == 14);
      st = (c == 0 || c == 10 || c == 15) ? S_IDLE : (c == 9) ? S_REL :
           (c == 14) ? S_RST : (c >= 11 && c <= 13) ? S_B : S_A;
      step($sformatf("midrst c%0d", c), st);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
